// File: rtl/watch_cmd_ctrl.sv
// Command sequencer between the UART receiver and the stopwatch: decodes received
// ASCII commands, runs the run/pause/stop FSM and owns the report request handshake.
module watch_cmd_ctrl #(
  parameter int unsigned REP_TIMEOUT = 1000,
  parameter int unsigned TO_W        = 10,
  parameter bit          UP_RESET    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rep_ack,
  output logic       run,
  output logic       paused,
  output logic       up,
  output logic       clear,
  output logic       rep_req,
  output logic       rep_err,
  output logic       bad_cmd
);

  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(REP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            run_q, run_d;
  logic            paused_q, paused_d;
  logic            up_q, up_d;
  logic            clear_q, clear_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic            bad_q, bad_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [7:0] fold_c;
  logic       is_c_c, is_g_c, is_p_c, is_u_c, is_r_c, is_bad_c;

  // Clearing bit 5 upper-cases letters; no non-letter byte folds onto a command letter.
  always_comb begin
    fold_c   = rx_data & 8'hDF;
    is_c_c   = rx_done && (fold_c == CMD_C);
    is_g_c   = rx_done && (fold_c == CMD_G);
    is_p_c   = rx_done && (fold_c == CMD_P);
    is_u_c   = rx_done && (fold_c == CMD_U);
    is_r_c   = rx_done && (fold_c == CMD_R);
    is_bad_c = rx_done && !(is_c_c || is_g_c || is_p_c || is_u_c || is_r_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      run_q    <= 1'b0;
      paused_q <= 1'b0;
      up_q     <= UP_RESET;
      clear_q  <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      paused_q <= paused_d;
      up_q     <= up_d;
      clear_q  <= clear_d;
      req_q    <= req_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    clear_d = 1'b0;
    bad_d   = is_bad_c;
    req_d   = req_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (is_c_c) begin
      state_d = ST_STOP;
      clear_d = 1'b1;
    end else if (is_g_c) begin
      state_d = ST_RUN;
    end else if (is_p_c) begin
      case (state_q)
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end

    if (is_u_c) begin
      up_d = ~up_q;
    end

    // Re-arm beats ack, ack beats timeout; an R while pending is otherwise dropped.
    if (req_q) begin
      if (is_r_c && rep_ack) begin
        cnt_d = '0;
      end else if (rep_ack) begin
        req_d = 1'b0;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        req_d = 1'b0;
        err_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else if (is_r_c) begin
      req_d = 1'b1;
      cnt_d = '0;
    end

    run_d    = (state_d == ST_RUN);
    paused_d = (state_d == ST_PAUSE);
  end

  assign run     = run_q;
  assign paused  = paused_q;
  assign up      = up_q;
  assign clear   = clear_q;
  assign rep_req = req_q;
  assign rep_err = err_q;
  assign bad_cmd = bad_q;

endmodule

// File: tb/tb_watch_cmd_ctrl.sv
// Self-checking bench for watch_cmd_ctrl: directed vector table, hand-written
// report/reset sequences and a randomized run against a behavioural model.
module tb_watch_cmd_ctrl;

  localparam int unsigned REP_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rep_ack;
  logic       run, paused, up, clear, rep_req, rep_err, bad_cmd;

  int checks = 0;
  int errors = 0;

  watch_cmd_ctrl #(
    .REP_TIMEOUT(REP_TIMEOUT),
    .TO_W       (4),
    .UP_RESET   (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rep_ack(rep_ack),
    .run    (run),
    .paused (paused),
    .up     (up),
    .clear  (clear),
    .rep_req(rep_req),
    .rep_err(rep_err),
    .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  // Expected vector order: {run, paused, up, clear, rep_req, rep_err, bad_cmd}
  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] BASE = 7'b0010000;
  localparam logic [6:0] REQ  = 7'b0010100;
  localparam logic [6:0] ERR  = 7'b0010010;

  function automatic logic [6:0] outs();
    return {run, paused, up, clear, rep_req, rep_err, bad_cmd};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {run,paused,up,clear,req,err,bad}=%b want %b",
               name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs from just after an edge, return just after the next edge.
  task automatic step(input logic d, input logic [7:0] data, input logic a);
    rx_done = d;
    rx_data = data;
    rep_ack = a;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    rep_ack = 1'b0;
  endtask

  function automatic vec_t mk(input logic d, input logic [7:0] data, input logic a,
                              input logic [6:0] exp);
    vec_t v;
    v.done = d; v.data = data; v.ack = a; v.exp = exp;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    rep_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Behavioural model: command meaning by letter, report tracked by age since request.
  typedef enum {M_STOP, M_RUN, M_PAUSE} mode_e;
  mode_e m_mode;
  logic  m_up, m_clr, m_req, m_err, m_bad;
  int    m_age;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
    return b;
  endfunction

  task automatic model_step(input logic d, input logic [7:0] data, input logic a);
    logic [7:0] c;
    logic       is_r;
    c = to_upper(data);
    is_r = d && (c == 8'h52);
    m_clr = 1'b0; m_err = 1'b0; m_bad = 1'b0;
    if (d) begin
      case (c)
        8'h43: begin m_mode = M_STOP; m_clr = 1'b1; end
        8'h47: m_mode = M_RUN;
        8'h50: if (m_mode == M_RUN) m_mode = M_PAUSE;
               else if (m_mode == M_PAUSE) m_mode = M_RUN;
        8'h55: m_up = !m_up;
        8'h52: ;
        default: m_bad = 1'b1;
      endcase
    end
    if (m_req) begin
      if (is_r && a) m_age = 0;
      else if (a) m_req = 1'b0;
      else if (m_age + 1 == int'(REP_TIMEOUT)) begin m_req = 1'b0; m_err = 1'b1; end
      else m_age++;
    end else if (is_r) begin
      m_req = 1'b1;
      m_age = 0;
    end
  endtask

  function automatic logic [6:0] model_outs();
    return {m_mode == M_RUN, m_mode == M_PAUSE, m_up, m_clr, m_req, m_err, m_bad};
  endfunction

  logic [7:0] cmds [10] = '{8'h43, 8'h63, 8'h47, 8'h67, 8'h50, 8'h70, 8'h55, 8'h75, 8'h52, 8'h72};

  initial begin
    do_reset();
    check("reset", BASE);

    vecs.push_back(mk(1, 8'h47, 0, 7'b1010000)); // G
    vecs.push_back(mk(1, 8'h70, 0, 7'b0110000)); // p
    vecs.push_back(mk(1, 8'h50, 0, 7'b1010000)); // P
    vecs.push_back(mk(0, 8'h00, 0, 7'b1010000));
    vecs.push_back(mk(1, 8'h63, 0, 7'b0011000)); // c in RUN
    vecs.push_back(mk(0, 8'h00, 0, 7'b0010000));
    vecs.push_back(mk(1, 8'h43, 0, 7'b0011000)); // C in STOP
    vecs.push_back(mk(1, 8'h75, 0, 7'b0000000)); // u
    vecs.push_back(mk(1, 8'h75, 0, 7'b0010000)); // u
    vecs.push_back(mk(1, 8'h47, 0, 7'b1010000)); // G
    vecs.push_back(mk(1, 8'h55, 0, 7'b1000000)); // U in RUN
    vecs.push_back(mk(1, 8'h75, 0, 7'b1010000)); // u
    vecs.push_back(mk(1, 8'h70, 0, 7'b0110000)); // p
    vecs.push_back(mk(1, 8'h55, 0, 7'b0100000)); // U in PAUSE
    vecs.push_back(mk(1, 8'h75, 0, 7'b0110000)); // u
    vecs.push_back(mk(1, 8'h41, 0, 7'b0110001)); // A bad
    vecs.push_back(mk(1, 8'h00, 0, 7'b0110001)); // back-to-back bad
    vecs.push_back(mk(0, 8'h00, 0, 7'b0110000));
    vecs.push_back(mk(1, 8'h67, 0, 7'b1010000)); // g from PAUSE
    vecs.push_back(mk(1, 8'h52, 0, 7'b1010100)); // R
    vecs.push_back(mk(0, 8'h00, 0, 7'b1010100));
    vecs.push_back(mk(1, 8'h72, 0, 7'b1010100)); // r while pending
    vecs.push_back(mk(0, 8'h00, 1, 7'b1010000)); // ack
    vecs.push_back(mk(0, 8'h00, 1, 7'b1010000)); // stray ack
    vecs.push_back(mk(1, 8'h63, 0, 7'b0011000)); // c
    vecs.push_back(mk(1, 8'h50, 0, 7'b0010000)); // P in STOP
    vecs.push_back(mk(0, 8'h47, 0, 7'b0010000)); // data without strobe
    vecs.push_back(mk(1, 8'hC7, 0, 7'b0010001)); // G with bit 7 set

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].done, vecs[i].data, vecs[i].ack);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Ack in the sixth high cycle; a second R while pending is ignored.
    step(1, 8'h52, 0);
    check("ack6_hi1", REQ);
    for (int i = 0; i < 5; i++) begin
      step(i == 1, 8'h52, 0);
      check($sformatf("ack6_hi%0d", i + 2), REQ);
    end
    step(0, 8'h00, 1);
    check("ack6_drop", BASE);

    // Timeout without ack.
    step(1, 8'h72, 0);
    check("to_hi1", REQ);
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 0);
      check($sformatf("to_hi%0d", i + 2), REQ);
    end
    step(0, 8'h00, 0);
    check("to_err", ERR);
    step(0, 8'h00, 0);
    check("to_err_end", BASE);

    // Ack on the expiry cycle suppresses rep_err.
    step(1, 8'h52, 0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 0);
    check("exp_hi8", REQ);
    step(0, 8'h00, 1);
    check("exp_ack", BASE);
    step(0, 8'h00, 0);
    check("exp_ack_noerr", BASE);

    // R together with ack re-arms the full timeout.
    step(1, 8'h52, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
    step(1, 8'h52, 1);
    check("rearm", REQ);
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 0);
      check($sformatf("rearm_hi%0d", i + 2), REQ);
    end
    step(0, 8'h00, 0);
    check("rearm_err", ERR);
    step(0, 8'h00, 0);

    // Asynchronous reset in the middle of a report.
    step(1, 8'h47, 0);
    step(1, 8'h75, 0);
    step(1, 8'h52, 0);
    check("prerst", 7'b1000100);
    #2 rst = 1'b1;
    #1 check("rst_async", BASE);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 8'h00, 0);
    check("rst_noerr", BASE);

    // Randomized run against the model.
    do_reset();
    m_mode = M_STOP; m_up = 1'b1; m_clr = 1'b0; m_req = 1'b0;
    m_err = 1'b0; m_bad = 1'b0; m_age = 0;
    for (int i = 0; i < 2000; i++) begin
      logic       d, a;
      logic [7:0] data;
      d = ($urandom_range(0, 9) < 4);
      a = ($urandom_range(0, 3) == 0);
      data = ($urandom_range(0, 9) < 6) ? cmds[$urandom_range(0, 9)] : 8'($urandom);
      model_step(d, data, a);
      step(d, data, a);
      check($sformatf("rand%0d", i), model_outs());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
